// File: rtl/counter_spi_master.sv
// Free-running 0..9999 up-counter that sends every new value to the slave board
// as a 16-bit SPI mode-0 frame (high byte first) and captures miso into a debug word.
module counter_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int TICK_DIV = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_run,
    input  logic        i_clear,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss,
    output logic [13:0] o_counter,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [15:0] o_rx_data,
    output logic [2:0]  o_dbg_state
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [13:0]   CNT_MAX    = 14'd9999;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_SCLK_HI = 3'd2,
        S_SCLK_LO = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // Handshake: a counter update (tick or clear) raises pend_q; the FSM consumes it
    // by snapshotting the counter when it leaves IDLE. Updates in that same cycle win.
    logic [PW-1:0] presc_q, presc_d;
    logic [13:0]   cnt_q, cnt_d;
    logic          pend_q, pend_d;
    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   tx_q, tx_d;
    logic [15:0]   rx_q, rx_d;
    logic [15:0]   rx_data_q, rx_data_d;
    logic          done_q, done_d;
    logic          tick, update, load, phase_end;

    always_comb begin
        tick    = i_run && (presc_q == PRESC_LAST);
        update  = i_clear || tick;
        presc_d = presc_q + PW'(1);
        if (i_clear || !i_run || tick) begin
            presc_d = '0;
        end
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = (cnt_q == CNT_MAX) ? 14'd0 : cnt_q + 14'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        load      = 1'b0;
        phase_end = (div_q == DIV_LAST);
        // Every non-idle state lasts exactly one sclk half-period.
        if (state_q != S_IDLE) begin
            div_d = phase_end ? '0 : div_q + DW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    load    = 1'b1;
                    tx_d    = {2'b00, cnt_q};
                    bit_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    state_d = S_SCLK_HI;
                    rx_d    = {rx_q[14:0], miso};
                end
            end
            S_SCLK_HI: begin
                if (phase_end) begin
                    state_d = S_SCLK_LO;
                    tx_d    = {tx_q[14:0], 1'b0};
                end
            end
            S_SCLK_LO: begin
                if (phase_end) begin
                    if (bit_q == 4'd15) begin
                        state_d   = S_GAP;
                        done_d    = 1'b1;
                        rx_data_d = rx_q;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = S_SCLK_HI;
                        rx_d    = {rx_q[14:0], miso};
                    end
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pend_d = update ? 1'b1 : (load ? 1'b0 : pend_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        ss           = (state_q == S_IDLE) || (state_q == S_GAP);
        sclk         = (state_q == S_SCLK_HI);
        mosi         = ((state_q == S_SETUP) || (state_q == S_SCLK_HI) ||
                        (state_q == S_SCLK_LO)) ? tx_q[15] : 1'b0;
        o_counter    = cnt_q;
        o_busy       = (state_q != S_IDLE);
        o_frame_done = done_q;
        o_rx_data    = rx_data_q;
        o_dbg_state  = state_q;
    end
endmodule

// File: tb/tb_counter_spi_master.sv
// Bench for counter_spi_master: vector table, hand-written corner sequences and
// randomized run/clear traffic checked against a counter model and an SPI slave decoder.
module tb_counter_spi_master;
    localparam int H  = 4;
    localparam int TD = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0, clear = 1'b0, miso = 1'b0;
    logic        sclk, mosi, ss, busy, frame_done;
    logic [13:0] counter;
    logic [15:0] rx_data;
    logic [2:0]  dbg;

    logic        w_run = 1'b0, w_clear = 1'b0, w_miso = 1'b0;
    logic        w_sclk, w_mosi, w_ss, w_busy, w_done;
    logic [13:0] w_counter;
    logic [15:0] w_rx;
    logic [2:0]  w_dbg;

    always #5 clk = ~clk;

    counter_spi_master #(.CLK_DIV(H), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .i_run(run), .i_clear(clear),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss),
        .o_counter(counter), .o_busy(busy), .o_frame_done(frame_done),
        .o_rx_data(rx_data), .o_dbg_state(dbg)
    );

    counter_spi_master #(.CLK_DIV(H), .TICK_DIV(2)) dut_w (
        .clk(clk), .reset(reset), .i_run(w_run), .i_clear(w_clear),
        .sclk(w_sclk), .mosi(w_mosi), .miso(w_miso), .ss(w_ss),
        .o_counter(w_counter), .o_busy(w_busy), .o_frame_done(w_done),
        .o_rx_data(w_rx), .o_dbg_state(w_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    endtask

    task automatic check_eq(input string name, input longint act, input longint req);
        check(name, act == req, act, req);
    endtask

    // Reference counter: every TD consecutive run cycles is one increment modulo 10000.
    int m_cnt = 0, m_streak = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt    <= 0;
            m_streak <= 0;
        end else if (clear) begin
            m_cnt    <= 0;
            m_streak <= 0;
        end else if (run) begin
            if (m_streak + 1 == TD) begin
                m_cnt    <= (m_cnt + 1) % 10000;
                m_streak <= 0;
            end else begin
                m_streak <= m_streak + 1;
            end
        end else begin
            m_streak <= 0;
        end
    end

    // Slave model for dut: decodes mosi, drives miso, scores frames.
    logic [15:0] exp_q[$];
    logic [15:0] miso_pat = 16'h0000;
    logic [15:0] rx_shift = 16'h0000, last_frame = 16'hFFFF;
    int  nbits = 0, low_len = 0, high_len = 0, frames = 0, done_pulses = 0, prev_cnt = 0;
    bit  ss_prev = 1'b1, sclk_prev = 1'b0, seen_frame = 1'b0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            exp_q.delete();
            nbits = 0; low_len = 0; high_len = 0;
            seen_frame = 1'b0; ss_prev = 1'b1; sclk_prev = 1'b0; prev_cnt = 0;
            miso = 1'b0;
        end else begin
            if (frame_done) done_pulses++;
            if (!ss && ss_prev) begin
                check_eq("sclk_low_at_ss_fall", sclk, 0);
                if (seen_frame) check("ss_high_gap", high_len >= H + 1, high_len, H + 1);
                exp_q.push_back({2'b00, 14'(prev_cnt)});
                nbits = 0; low_len = 0;
            end
            if (!ss && sclk && !sclk_prev) begin
                rx_shift = {rx_shift[14:0], mosi};
                nbits++;
            end
            if (ss && !ss_prev) begin
                check_eq("sclk_low_at_ss_rise", sclk, 0);
                check_eq("ss_low_len", low_len, 33 * H);
                check_eq("frame_bits", nbits, 16);
                check_eq("frame_done_at_ss_rise", frame_done, 1);
                check_eq("rx_data", rx_data, miso_pat);
                if (exp_q.size() == 0) check("frame_unexpected", 1'b0, rx_shift, 0);
                else check_eq("frame_value", rx_shift, exp_q.pop_front());
                last_frame = rx_shift;
                frames++;
                seen_frame = 1'b1;
                high_len = 0;
                nbits = 0;
            end
            if (ss) high_len++;
            else low_len++;
            ss_prev   = ss;
            sclk_prev = sclk;
            prev_cnt  = m_cnt;
            if (nbits < 16) miso = miso_pat[15 - nbits];
            else miso = 1'b0;
        end
    end

    // Decoder for the wrap instance.
    logic [15:0] w_shift = 16'h0000, w_last = 16'hFFFF;
    bit w_sclk_prev = 1'b0, w_ss_prev = 1'b1;
    initial forever begin
        @(negedge clk);
        if (!w_ss && w_sclk && !w_sclk_prev) w_shift = {w_shift[14:0], w_mosi};
        if (w_ss && !w_ss_prev && !reset) w_last = w_shift;
        w_sclk_prev = w_sclk;
        w_ss_prev   = w_ss;
    end

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        run = 1'b1;
        repeat (n * TD) @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        for (int k = 0; k < 3000 && quiet < 3; k++) begin
            @(negedge clk);
            if (!busy) quiet++;
            else quiet = 0;
        end
        check(name, quiet >= 3, quiet, 3);
    endtask

    typedef struct {
        bit          do_clear;
        int          ticks;
        logic [15:0] miso_v;
        int          nframes;
        logic [15:0] exp_frame;
        logic [13:0] exp_cnt;
    } vec_t;
    vec_t vecs[7];

    int f0, d0, len, op;

    initial begin
        vecs[0] = '{1'b1, 0,   16'hA55A, 1, 16'h0000, 14'd0};
        vecs[1] = '{1'b0, 1,   16'h1234, 1, 16'h0001, 14'd1};
        vecs[2] = '{1'b0, 1,   16'hFFFF, 1, 16'h0002, 14'd2};
        vecs[3] = '{1'b0, 1,   16'h0000, 1, 16'h0003, 14'd3};
        vecs[4] = '{1'b1, 0,   16'h8001, 1, 16'h0000, 14'd0};
        vecs[5] = '{1'b1, 0,   16'h5AA5, 1, 16'h0000, 14'd0};
        vecs[6] = '{1'b0, 137, 16'hC3C3, 0, 16'h0089, 14'd137};

        repeat (3) @(negedge clk);
        check_eq("rst_ss", ss, 1);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_mosi", mosi, 0);
        check_eq("rst_counter", counter, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_rx_data", rx_data, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            f0 = frames;
            miso_pat = vecs[i].miso_v;
            if (vecs[i].do_clear) pulse_clear();
            else do_ticks(vecs[i].ticks);
            wait_idle($sformatf("vec%0d_idle", i));
            if (vecs[i].nframes != 0)
                check_eq($sformatf("vec%0d_nframes", i), frames - f0, vecs[i].nframes);
            check_eq($sformatf("vec%0d_frame", i), last_frame, vecs[i].exp_frame);
            check_eq($sformatf("vec%0d_counter", i), counter, vecs[i].exp_cnt);
            check_eq($sformatf("vec%0d_rx", i), rx_data, vecs[i].miso_v);
        end

        // Clear and tick land on the same edge: clear wins, one frame of zero.
        miso_pat = 16'h1111;
        f0 = frames;
        run = 1'b1;
        repeat (TD - 1) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        run = 1'b0;
        wait_idle("clr_tick_idle");
        check_eq("clr_tick_nframes", frames - f0, 1);
        check_eq("clr_tick_frame", last_frame, 0);
        check_eq("clr_tick_counter", counter, 0);

        // Reset in the middle of a frame, after bit 7.
        miso_pat = 16'h0F0F;
        f0 = frames;
        d0 = done_pulses;
        pulse_clear();
        for (int k = 0; k < 500 && nbits < 8; k++) @(negedge clk);
        check("midrst_reached_bit7", nbits >= 8, nbits, 8);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("midrst_ss", ss, 1);
        check_eq("midrst_sclk", sclk, 0);
        check_eq("midrst_mosi", mosi, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_rx_data", rx_data, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check_eq("midrst_no_frame", frames - f0, 0);
        check_eq("midrst_no_done", done_pulses - d0, 0);
        miso_pat = 16'h3C3C;
        pulse_clear();
        wait_idle("post_rst_idle");
        check_eq("post_rst_nframes", frames - f0, 1);
        check_eq("post_rst_frame", last_frame, 0);
        check_eq("post_rst_rx", rx_data, 16'h3C3C);

        // Randomized run/clear traffic against the model.
        miso_pat = 16'($urandom);
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                pulse_clear();
            end else if (op == 3) begin
                repeat ($urandom_range(1, 150)) @(negedge clk);
            end else begin
                len = $urandom_range(1, 80);
                run = 1'b1;
                for (int j = 0; j < len; j++) begin
                    clear = ($urandom_range(0, 15) == 0);
                    @(negedge clk);
                end
                clear = 1'b0;
                run = 1'b0;
            end
            @(negedge clk);
            check_eq("rand_counter", counter, m_cnt);
        end
        wait_idle("rand_idle");
        check_eq("rand_queue_empty", exp_q.size(), 0);

        // Wrap: advance the fast instance to 9999, then one more tick.
        w_run = 1'b1;
        for (int k = 0; k < 25000 && w_counter != 14'd9999; k++) @(negedge clk);
        w_run = 1'b0;
        check_eq("wrap_reach_9999", w_counter, 9999);
        repeat (300) @(negedge clk);
        check_eq("wrap_frame_9999", w_last, 9999);
        w_run = 1'b1;
        repeat (2) @(negedge clk);
        w_run = 1'b0;
        repeat (300) @(negedge clk);
        check_eq("wrap_counter_0", w_counter, 0);
        check_eq("wrap_frame_0", w_last, 0);

        check_eq("done_pulse_count", done_pulses, frames);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/counter_spi_master.md
# counter_spi_master

Master-side counterpart of the SPI up-counter link: free-running 0–9999 up-counter whose every new value is sent to the slave board as a two-byte SPI frame (high byte first).
- Generates `sclk`, `mosi` and `ss` itself and captures `miso` into a debug word.
- Sits in the master-board top level between the run/clear button logic and the board SPI pins.

## Interface
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles (H); legal range ≥2.
- `TICK_DIV`, default 10_000_000: `clk` cycles between counter increments while running.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `i_run`  input  1  level; 1 = counter advances every TICK_DIV cycles.
- `i_clear`  input  1  single-cycle pulse; counter to 0 and frame request.
- `sclk`  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- `mosi`  output  1  SPI data to slave, MSB first.
- `miso`  input  1  SPI data from slave.
- `ss`  output  1  slave select, active low.
- `o_counter`  output  14  current counter value.
- `o_busy`  output  1  high from frame start through the end of the post-frame gap.
- `o_frame_done`  output  1  one-cycle pulse at frame end.
- `o_rx_data`  output  16  the 16 `miso` bits of the last completed frame.

## Operation
- Reset values:
  - `ss`=1, `sclk`=0, `mosi`=0.
  - `o_counter`=0, `o_busy`=0, `o_frame_done`=0, `o_rx_data`=0.
  - Prescaler 0, pending flag 0, FSM in IDLE.
- Prescaler:
  - Counts while `i_run`=1; held at 0 while `i_run`=0.
  - Terminal count TICK_DIV-1 produces an internal tick.
- Counter:
  - Tick: counter +1; 9999 wraps to 0.
  - `i_clear`: counter to 0 and prescaler to 0.
  - `i_clear` and tick in the same cycle: clear wins and one request is raised.
  - A clear while the counter is already 0 still raises a request.
- Request handling:
  - Every counter update (tick or clear) sets the pending flag.
  - The flag holds at most one request; several updates during a frame collapse into one.
- Frame snapshot, taken on the FSM's transition out of IDLE (which clears pending):
  - byte0 = {2'b00, counter[13:8]}, byte1 = counter[7:0].
  - 16-bit shift register = {byte0, byte1}.
  - Counter changes after the snapshot do not alter the frame in flight.
- FSM states: IDLE → SETUP → SCLK_HI ↔ SCLK_LO (16 bits) → GAP → IDLE.
  - IDLE: `ss`=1, `sclk`=0. If pending=1, load the snapshot and go to SETUP.
  - SETUP (H cycles): `ss`=0, `sclk`=0, `mosi` = bit15.
  - SCLK_HI (H cycles): `sclk`=1. On entry (rising edge), shift `miso` into the rx shift register.
  - SCLK_LO (H cycles): `sclk`=0. On entry (falling edge), `mosi` advances to the next bit. After bit 0's low phase, go to GAP.
  - GAP (H cycles): `ss`=1, `sclk`=0, `mosi`=0.
    - On entry: `o_frame_done` pulses and `o_rx_data` loads.
    - On exit: return to IDLE.
- `ss` stays low across both bytes with no inter-byte gap; the slave frames the pair by `ss`.
- `o_busy` = 1 in every state except IDLE.

## Timing
- Request → frame start: a counter update in cycle N sets pending at N+1; `ss` falls at N+2 if the FSM is IDLE.
- `ss` low duration: 33·H cycles (SETUP + 16 × 2H). With H=4 this is 132 cycles.
- Frame-to-frame minimum spacing: 34·H + 1 cycles (GAP plus one IDLE cycle).
- Bit timing:
  - `mosi` is stable for ≥H cycles before each `sclk` rising edge.
  - `sclk` is low at both `ss` edges.
- `o_frame_done` is asserted in the same cycle `ss` returns high.
- `o_counter` updates the cycle after the tick or clear.
- Reset asserted mid-frame:
  - All outputs take their reset values immediately (asynchronously).
  - The partial frame is abandoned: no `o_frame_done`, no `o_rx_data` update.
- Pending request arriving during GAP: served after the next IDLE cycle; never dropped.

## Test plan
- Reset, then `i_clear` pulse (CLK_DIV=4): exactly one frame, `mosi` bits 0x0000, `ss` low for 132 cycles; `o_frame_done` pulses once.
- TICK_DIV=400, `i_run`=1: successive frames carry 0x0001, 0x0002, 0x0003; a slave model decodes the same values; `o_counter` matches.
- Preload to 9999 (via ticks with TICK_DIV=2 and 9999 advances) then one more tick: frame carries 0x0000 and `o_counter`=0.
- TICK_DIV=20 (faster than a frame): each frame carries the counter value at its start; no frame overlaps; `ss` high ≥H cycles between frames.
- `miso` driven with 0xA55A, sampled on rising edges: `o_rx_data`=0xA55A after `o_frame_done`.
- Assert `reset` after bit 7 of a frame: `ss`=1, `sclk`=0 immediately; no `o_frame_done`; after release, the next `i_clear` produces a clean 0x0000 frame.
